// File: rtl/cpc_rom_loader_if.sv
// SDRAM byte-write port driven by the ROM loader: req/ack handshake with
// the head FIFO entry presented on addr/bank/data.
interface cpc_rom_loader_if;
    logic        mem_req;
    logic        mem_ack;
    logic [22:0] mem_addr;
    logic        mem_bank;
    logic [7:0]  mem_data;

    modport master (output mem_req, mem_addr, mem_bank, mem_data, input mem_ack);
    modport slave  (input mem_req, mem_addr, mem_bank, mem_data, output mem_ack);
endinterface

// File: rtl/cpc_rom_loader.sv
// Maps the linear ROM download onto the CPC ROM pages of both model banks,
// queues the bytes toward SDRAM, and tracks which 16K pages are fully loaded.
module cpc_rom_loader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   dl_active,
    input  logic                   dl_wr,
    input  logic [24:0]            dl_addr,
    input  logic [7:0]             dl_data,
    cpc_rom_loader_if.master       mem,
    input  logic [8:0]             page_sel,
    input  logic                   bank_sel,
    output logic [7:0]             rom_mask,
    output logic [7:0]             rom_valid,
    output logic                   busy,
    output logic                   overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic        bank;
        logic [22:0] addr;
        logic [7:0]  data;
    } entry_t;

    function automatic logic [8:0] slot_page(input logic [1:0] slot);
        case (slot)
            2'd0:    return 9'h000;
            2'd1:    return 9'h100;
            2'd2:    return 9'h107;
            default: return 9'h1FF;
        endcase
    endfunction

    function automatic logic [1:0] page_slot(input logic [8:0] pg);
        case (pg)
            9'h100:  return 2'd1;
            9'h107:  return 2'd2;
            9'h1FF:  return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    entry_t          fifo [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            dl_active_q;

    logic [10:0]     img_page;
    logic            mapped, push_req, push, pop, empty, full, dl_rise;
    entry_t          new_entry, head;
    logic [1:0]      head_slot, mask_slot;

    assign img_page  = dl_addr[24:14];
    assign mapped    = (img_page[10:3] == 8'd0);
    assign push_req  = dl_wr & dl_active & mapped;
    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = mem.mem_ack & ~empty;
    // A full FIFO still takes the byte when the head leaves in the same cycle.
    assign push      = push_req & (~full | pop);
    assign dl_rise   = dl_active & ~dl_active_q;

    assign new_entry = '{bank: img_page[2],
                         addr: {slot_page(img_page[1:0]), dl_addr[13:0]},
                         data: dl_data};
    assign head      = fifo[rd_ptr];
    assign head_slot = page_slot(head.addr[22:14]);

    always_ff @(posedge clk_sys) begin
        if (push) fifo[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            dl_active_q <= 1'b0;
            rom_valid   <= '0;
            overflow    <= 1'b0;
        end else begin
            dl_active_q <= dl_active;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            // The last byte of a 16K page leaving the FIFO marks the page committed.
            if (dl_rise)
                rom_valid <= '0;
            else if (pop && head.addr[13:0] == 14'h3FFF)
                rom_valid[{head.bank, head_slot}] <= 1'b1;
            if (dl_rise)
                overflow <= 1'b0;
            else if (push_req && !push)
                overflow <= 1'b1;
        end
    end

    assign mem.mem_req  = ~empty;
    assign mem.mem_addr = head.addr;
    assign mem.mem_bank = head.bank;
    assign mem.mem_data = head.data;
    assign busy         = dl_active | ~empty;

    assign mask_slot = page_slot(page_sel);

    // RAM passes through; unmapped or not-yet-loaded ROM pages read as FF.
    always_comb begin
        rom_mask = 8'hFF;
        if (!page_sel[8])
            rom_mask = 8'h00;
        else if ((page_sel == 9'h100 || page_sel == 9'h107 || page_sel == 9'h1FF) &&
                 rom_valid[{bank_sel, mask_slot}])
            rom_mask = 8'h00;
    end
endmodule

// File: tb/tb_cpc_rom_loader.sv
// Randomized scoreboard bench for cpc_rom_loader against an image-level model.
module tb_cpc_rom_loader;
    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        dl_active = 1'b0, dl_wr = 1'b0;
    logic [24:0] dl_addr = '0;
    logic [7:0]  dl_data = '0;
    logic [8:0]  page_sel = '0;
    logic        bank_sel = 1'b0;
    logic [7:0]  rom_mask, rom_valid;
    logic        busy, overflow;

    cpc_rom_loader_if mif();

    cpc_rom_loader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .dl_active(dl_active), .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .mem(mif),
        .page_sel(page_sel), .bank_sel(bank_sel),
        .rom_mask(rom_mask), .rom_valid(rom_valid), .busy(busy), .overflow(overflow)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic        bank;
        logic [22:0] addr;
        logic [7:0]  data;
    } exp_t;

    exp_t        sbq[$];     // expected SDRAM writes, consumed by the monitor
    logic [24:0] mq[$];      // image offsets held in the model FIFO
    logic [7:0]  mvalid = '0;
    logic        movf = 1'b0;
    logic        prev_act = 1'b0;
    int          checks = 0, passes = 0;

    function automatic logic [8:0] rom_page(input int p);
        case (p % 4)
            0:       return 9'h000;
            1:       return 9'h100;
            2:       return 9'h107;
            default: return 9'h1FF;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    endtask

    // One clock: drive inputs, advance the image-level model, check outputs.
    task automatic tick(input logic act, input logic wr, input logic [24:0] a,
                        input logic [7:0] d, input logic ack);
        bit pop, preq, acc, rise;
        int p;
        logic [24:0] o;
        exp_t e;
        dl_active = act; dl_wr = wr; dl_addr = a; dl_data = d; mif.mem_ack = ack;
        @(posedge clk_sys);
        p    = int'(a >> 14);
        pop  = ack && mq.size() > 0;
        preq = reset_n && wr && act && p < 8;
        acc  = preq && (mq.size() < DEPTH || pop);
        rise = reset_n && act && !prev_act;
        if (pop && reset_n) begin
            o = mq.pop_front();
            if (o[13:0] == 14'h3FFF) mvalid[o[16:14]] = 1'b1;
        end
        if (acc) begin
            mq.push_back(a);
            e.bank = p[2];
            e.addr = {rom_page(p), a[13:0]};
            e.data = d;
            sbq.push_back(e);
        end
        if (preq && !acc) movf = 1'b1;
        if (rise) begin mvalid = '0; movf = 1'b0; end
        prev_act = reset_n ? act : 1'b0;
        #1;
        chk("mem_req", mif.mem_req, (mq.size() > 0));
        chk("busy", busy, (act || mq.size() > 0));
        chk("overflow", overflow, movf);
        chk("rom_valid", rom_valid, mvalid);
    endtask

    task automatic drain(input logic act);
        int n = 0;
        while (mq.size() > 0 && n < 200) begin
            tick(act, 1'b0, '0, '0, 1'($urandom_range(0, 1)));
            n++;
        end
        tick(act, 1'b0, '0, '0, 1'b0);
        chk("sb_drained", sbq.size(), 0);
    endtask

    task automatic mask_chk(input logic [8:0] pg, input logic bk, input logic [7:0] want);
        page_sel = pg; bank_sel = bk;
        #1;
        chk("rom_mask", rom_mask, want);
    endtask

    exp_t me;
    always @(negedge clk_sys) begin
        if (reset_n && mif.mem_req === 1'b1 && mif.mem_ack === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: addr %h with empty scoreboard", mif.mem_addr);
            end else begin
                me = sbq.pop_front();
                chk("wr_addr", mif.mem_addr, me.addr);
                chk("wr_bank", mif.mem_bank, me.bank);
                chk("wr_data", mif.mem_data, me.data);
            end
        end
    end

    initial begin
        logic [24:0] off;
        logic [24:0] offs2 [4];
        logic ack;
        mif.mem_ack = 1'b0;

        // Reset state
        #3;
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        chk("rst_valid", rom_valid, 8'h00);
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        reset_n = 1'b1;

        // Single byte held until acked
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b1, 25'h0, 8'hA5, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 1'b0, '0, '0, 1'b0);
            chk("hold_addr", mif.mem_addr, 23'h000000);
            chk("hold_bank", mif.mem_bank, 1'b0);
            chk("hold_data", mif.mem_data, 8'hA5);
        end
        tick(1'b1, 1'b0, '0, '0, 1'b1);
        chk("ack_req_low", mif.mem_req, 1'b0);

        // Page mapping, then an out-of-range page with the FIFO full
        offs2[0] = 25'h04000; offs2[1] = 25'h08000; offs2[2] = 25'h0C000; offs2[3] = 25'h10000;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, offs2[i] + 25'($urandom_range(0, 16383)),
                                         8'($urandom), 1'b0);
        chk("head_page", mif.mem_addr[22:14], 9'h100);
        tick(1'b1, 1'b1, 25'h20000, 8'h5A, 1'b0);
        chk("unmapped_no_ovf", overflow, 1'b0);
        drain(1'b1);

        // Overflow, then push accepted while full with a simultaneous ack
        for (int i = 0; i < 6; i++)
            tick(1'b1, 1'b1, 25'($urandom_range(0, 8 * 16384 - 1)), 8'($urandom), 1'b0);
        chk("ovf_set", overflow, 1'b1);
        tick(1'b1, 1'b1, 25'($urandom_range(0, 8 * 16384 - 1)), 8'($urandom), 1'b1);
        drain(1'b1);

        // Full 64K image for bank 0 with ack stalls near page boundaries
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        chk("ovf_clr_on_rise", overflow, 1'b0);
        off = '0;
        while (off < 25'h10000) begin
            ack = (off[13:8] == 6'h00 || off[13:8] == 6'h3F) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mq.size() < DEPTH) begin
                tick(1'b1, 1'b1, off, 8'($urandom), ack);
                off++;
            end else begin
                tick(1'b1, 1'b0, '0, '0, ack);
            end
        end
        drain(1'b1);
        chk("image_valid", rom_valid, 8'h0F);
        mask_chk(9'h107, 1'b0, 8'h00);
        mask_chk(9'h107, 1'b1, 8'hFF);
        mask_chk(9'h100, 1'b0, 8'h00);
        mask_chk(9'h1FF, 1'b1, 8'hFF);
        mask_chk(9'h055, 1'b1, 8'h00);
        mask_chk(9'h1AB, 1'b0, 8'hFF);

        // New download clears rom_valid; busy holds through drain
        tick(1'b0, 1'b1, 25'h0123, 8'h77, 1'b0);
        chk("valid_kept_low", rom_valid, 8'h0F);
        tick(1'b1, 1'b0, '0, '0, 1'b0);
        chk("valid_clr_rise", rom_valid, 8'h00);
        mask_chk(9'h107, 1'b0, 8'hFF);
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 25'($urandom_range(0, 8 * 16384 - 1)), 8'($urandom), 1'b0);
        tick(1'b0, 1'b0, '0, '0, 1'b0);
        chk("busy_draining", busy, 1'b1);
        drain(1'b0);
        chk("busy_idle", busy, 1'b0);

        // Reset mid-transfer discards the FIFO; stray ack afterwards
        for (int i = 0; i < 3; i++)
            tick(1'b1, 1'b1, 25'($urandom_range(0, 8 * 16384 - 1)), 8'($urandom), 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_req", mif.mem_req, 1'b0);
        chk("rst_mid_busy", busy, 1'b1);
        mq.delete(); sbq.delete(); mvalid = '0; movf = 1'b0; prev_act = 1'b0;
        tick(1'b0, 1'b0, '0, '0, 1'b1);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0, '0, 1'b1);
        tick(1'b1, 1'b1, 25'h1C3FF, 8'h3C, 1'b0);
        drain(1'b1);
        chk("post_rst_valid", rom_valid, 8'h00);

        chk("sb_empty", sbq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
